cv32e_data_mem_slave: RTL and testbench
=======================================

CV32E_DATA_MEM_SLAVE -- requirements
Module: cv32e_data_mem_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096: number of 32-bit words in the backing store, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: cycles from request to grant when wait states are compiled in; range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0001_0000: byte address of word 0, aligned to MEM_WORDS*4.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  block clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 data_req_i  input  1  request from the core.
REQ-008 data_addr_i  input  32  byte address.
REQ-009 data_we_i  input  1  1 = write, 0 = read.
REQ-010 data_be_i  input  4  byte enables; bit n selects lane [8n+7:8n].
REQ-011 data_wdata_i  input  32  write data.
REQ-012 data_gnt_o  output  1  grant, which accepts the address phase.
REQ-013 data_rvalid_o  output  1  response phase valid.
REQ-014 data_rdata_o  output  32  read data, meaningful only while data_rvalid_o = 1.

Function
REQ-015 SHALL sample addr, we, be and wdata in the cycle data_gnt_o = data_req_i = 1 (the accept cycle).
REQ-016 SHALL assert data_rvalid_o for exactly one cycle, in the cycle after each accept, for both reads and writes.
REQ-017 SHALL hold at most one outstanding transaction, so a new accept may coincide with the rvalid of the previous one.
REQ-018 Read: data_rdata_o SHALL equal the stored word at index data_addr_i[log2(MEM_WORDS)+1:2] in the rvalid cycle.
REQ-019 Write: SHALL update only the lanes whose enable bit is 1; data_rdata_o SHALL be 32'h0 in the write's rvalid cycle.
REQ-020 An address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4) SHALL still be granted and answered; a write SHALL be dropped, and a read SHALL return 32'h0.
REQ-021 SHALL ignore data_addr_i[1:0]; unaligned accesses resolve to the containing word.
REQ-022 data_rdata_o SHALL hold its last value while data_rvalid_o = 0.

Reset
REQ-023 While rst_ni = 0: data_gnt_o = 0, data_rvalid_o = 0, data_rdata_o = 32'h0, wait counter = 0, state = IDLE.
REQ-024 Reset mid-transaction SHALL discard the transaction with no rvalid after release; memory contents are not reset.
REQ-025 In the first cycle after release, SHALL accept a request under the same rules as from IDLE.

Configuration
REQ-026 Macro DMEM_WAIT_STATE_EN SHALL select the grant behaviour at compile time.
REQ-027 Defined: SHALL use a state machine with states IDLE and WAIT, plus a 4-bit counter.
- IDLE with req and WAIT_CYCLES = 0: grant in the same cycle.
- IDLE with req and WAIT_CYCLES > 0: go to WAIT with counter = 1.
- WAIT: while counter < WAIT_CYCLES, increment.
- WAIT with counter = WAIT_CYCLES: assert gnt combinationally, return to IDLE, counter = 0.
REQ-028 Defined: if data_req_i drops while in WAIT, SHALL return to IDLE with counter = 0 and no grant.
REQ-029 Defined: after each accept, SHALL restart the wait count from IDLE, giving one accept per WAIT_CYCLES+1 cycles.
REQ-030 Not defined: data_gnt_o SHALL equal data_req_i combinationally outside reset, giving one accept per cycle; no FSM or counter is present.

Structure
REQ-031 Package cv32e_dmem_pkg SHALL hold the state enum (IDLE, WAIT), the counter width constant (4) and the out-of-range read value (32'h0).
REQ-032 Sub-module cv32e_dmem_array SHALL implement the byte-enable word array.
- One synchronous write port.
- One synchronous read port with 1-cycle latency.
- Parameter MEM_WORDS.

Verification
REQ-033 Reset release, then write addr 32'h0001_0004, be 4'hF, wdata 32'hCAFE_F00D, then read the same address -> rvalid 1 cycle after each grant, read rdata 32'hCAFE_F00D.
REQ-034 Preload 32'h1122_3344 at 0x0001_0008, write be 4'b0101, wdata 32'hAABB_CCDD, then read -> rdata 32'h11BB_33DD.
REQ-035 Macro defined, WAIT_CYCLES=2, req held high -> grants every 3rd cycle, each rvalid follows its grant by 1 cycle.
REQ-036 Macro not defined: 8 back-to-back reads at 0x0001_0000..0x0001_001C -> 8 consecutive grants and 8 consecutive rvalids, with data in order.
REQ-037 Read at 0x0000_0000 (out of range) -> granted, rdata 32'h0; write 32'hFFFF_FFFF there -> memory at 0x0001_0000 unchanged.
REQ-038 Macro defined, rst_ni pulled low in the WAIT state -> gnt and rvalid stay 0 through reset, counter = 0, no rvalid after release.

Source files
------------

// File: rtl/cv32e_dmem_pkg.sv
// -----------------------------------------------------------------------------
// cv32e_dmem_pkg
// Shared types and constants for the CV32E data-memory slave:
//   dmem_state_e : grant FSM states (IDLE, WAIT), used when DMEM_WAIT_STATE_EN
//                  is defined
//   CNT_W        : width of the wait-state counter
//   OOR_RDATA    : value returned for reads outside the mapped window and in
//                  the response cycle of every write
// -----------------------------------------------------------------------------
package cv32e_dmem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

  localparam int unsigned CNT_W = 4;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

endpackage : cv32e_dmem_pkg

// File: rtl/cv32e_dmem_array.sv
// -----------------------------------------------------------------------------
// cv32e_dmem_array
// Word-organised backing store with per-byte write enables.
//   clk_i    : clock
//   we_i     : write strobe, lanes selected by be_i are written at the edge
//   re_i     : read strobe, rdata_o is valid the cycle after re_i
//   addr_i   : word index shared by both ports
//   be_i     : byte enables, bit n selects lane [8n+7:8n]
//   wdata_i  : write data
//   rdata_o  : registered read data, holds while re_i is low
// Contents are deliberately not reset.
// -----------------------------------------------------------------------------
module cv32e_dmem_array #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : cv32e_dmem_array

// File: rtl/cv32e_data_mem_slave.sv
// -----------------------------------------------------------------------------
// cv32e_data_mem_slave
// OBI-style data memory slave for the CV32E core: one outstanding transaction,
// response (rvalid) exactly one cycle after each accepted address phase.
//
// Ports:
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   data_req_i     : request
//   data_addr_i    : byte address (bits [1:0] ignored)
//   data_we_i      : 1 = write, 0 = read
//   data_be_i      : byte enables
//   data_wdata_i   : write data
//   data_gnt_o     : grant (accepts the address phase)
//   data_rvalid_o  : response valid, one cycle per accept
//   data_rdata_o   : read data; 0 for writes and out-of-window reads; holds its
//                    last value while data_rvalid_o is low
//
// Compile-time option:
//   DMEM_WAIT_STATE_EN : when defined, a small FSM inserts WAIT_CYCLES wait
//                        states between request and grant. When undefined the
//                        grant follows the request combinationally.
// -----------------------------------------------------------------------------
module cv32e_data_mem_slave
  import cv32e_dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic          gnt;
  logic          accept;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          arr_we;
  logic          arr_re;
  logic [31:0]   arr_rdata;

  // The window is aligned to its own size, so a match on the upper address
  // bits is equivalent to the full [BASE, BASE+size) range check.
  assign in_range = (data_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign word_idx = data_addr_i[AW+1:2];

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_addr_i[1:0];

`ifdef DMEM_WAIT_STATE_EN
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every accept returns to IDLE, so the count restarts for the next request
  // and the accept rate is one per WAIT_CYCLES+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (WAIT_CYCLES == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          // Core withdrew the request: abandon the wait without granting.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < WAIT_CNT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          gnt     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  logic [CNT_W-1:0] unused_wait_cfg;
  assign unused_wait_cfg = CNT_W'(WAIT_CYCLES);

  always_comb begin
    gnt = data_req_i;
  end
`endif

  // Grant is forced low while reset is asserted, independent of the clock.
  assign data_gnt_o = gnt & rst_ni;
  assign accept     = data_gnt_o & data_req_i;
  assign arr_we     = accept &  data_we_i & in_range;
  assign arr_re     = accept & ~data_we_i & in_range;

  cv32e_dmem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (word_idx),
    .be_i    (data_be_i),
    .wdata_i (data_wdata_i),
    .rdata_o (arr_rdata)
  );

  logic        rvalid_q, rvalid_d;
  logic        rd_hit_q, rd_hit_d;
  logic [31:0] hold_q, hold_d;

  // Response stage: remembers whether the accepted transaction was an
  // in-window read, so the response picks array data or the fixed zero.
  always_comb begin
    rvalid_d = accept;
    rd_hit_d = arr_re;
    hold_d   = data_rdata_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rd_hit_q <= 1'b0;
      hold_q   <= 32'h0;
    end else begin
      rvalid_q <= rvalid_d;
      rd_hit_q <= rd_hit_d;
      hold_q   <= hold_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rvalid_q ? (rd_hit_q ? arr_rdata : OOR_RDATA) : hold_q;

endmodule : cv32e_data_mem_slave

// File: tb/tb_cv32e_data_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_cv32e_data_mem_slave
// Self-checking bench for cv32e_data_mem_slave. Table-driven transactions push
// their expected read data into a scoreboard queue at the accept; a monitor
// pops and compares at each rvalid, and checks rvalid timing and rdata hold.
// -----------------------------------------------------------------------------
module tb_cv32e_data_mem_slave;

  localparam int unsigned MEM_WORDS   = 64;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam logic [31:0] BASE_ADDR   = 32'h0001_0000;
`ifdef DMEM_WAIT_STATE_EN
  localparam int EXP_DIFF = WAIT_CYCLES + 1;
`else
  localparam int EXP_DIFF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  cv32e_data_mem_slave #(
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BASE_ADDR   (BASE_ADDR)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          acc_cyc[$];
  logic        acc_prev = 1'b0;
  logic [31:0] last_rd = 32'h0;
  vec_t        vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: rvalid must follow each accept by exactly one cycle, rdata is
  // compared against the scoreboard, and rdata must hold between responses.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        acc_prev = 1'b0;
        last_rd  = 32'h0;
      end else begin
        if (acc_prev || data_rvalid_o)
          check("rvalid_timing", {31'b0, data_rvalid_o}, {31'b0, acc_prev});
        if (data_rvalid_o) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rvalid_unexpected: got rvalid with rdata %h, expected none", data_rdata_o);
          end else begin
            e = exp_q.pop_front();
            check("rdata", data_rdata_o, e);
          end
          last_rd = data_rdata_o;
        end else begin
          check("rdata_hold", data_rdata_o, last_rd);
        end
        acc_prev = data_gnt_o && req;
        if (acc_prev) acc_cyc.push_back(cyc);
      end
    end
  end

  // Drives one transaction and returns just after the accepting edge, with
  // req still high so that calls chain back-to-back.
  task automatic run_vec(input vec_t v);
    bit got;
    got   = 1'b0;
    we    = v.we;
    addr  = v.addr;
    be    = v.be;
    wdata = v.wdata;
    req   = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (data_gnt_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL gnt_timeout: got no grant for addr %h, expected one within 40 cycles", v.addr);
      req = 1'b0;
    end else begin
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 32'h0001_0004, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[1]  = '{1'b0, 32'h0001_0004, 4'hF, 32'h0,         32'hCAFE_F00D};
    vecs[2]  = '{1'b1, 32'h0001_0008, 4'hF, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 32'h0001_0008, 4'h5, 32'hAABB_CCDD, 32'h0};
    vecs[4]  = '{1'b0, 32'h0001_0008, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[5]  = '{1'b0, 32'h0001_000B, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[6]  = '{1'b1, 32'h0001_0006, 4'h8, 32'h7700_0000, 32'h0};
    vecs[7]  = '{1'b0, 32'h0001_0005, 4'hF, 32'h0,         32'h77FE_F00D};
    vecs[8]  = '{1'b1, 32'h0001_0004, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 32'h0001_0004, 4'hF, 32'h0,         32'h77FE_F00D};
    vecs[10] = '{1'b1, 32'h0001_0000, 4'hF, 32'h1357_2468, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 32'h0001_0100, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[14] = '{1'b0, 32'h0001_0100, 4'hF, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         32'h1357_2468};
    vecs[16] = '{1'b1, 32'h0001_00FC, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[17] = '{1'b0, 32'h0001_00FC, 4'hF, 32'h0,         32'hDEAD_BEEF};

    // Reset state with a request pending.
    req  = 1'b1;
    addr = 32'h0001_0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_gnt", {31'b0, data_gnt_o}, 32'h0);
      check("reset_rvalid", {31'b0, data_rvalid_o}, 32'h0);
      check("reset_rdata", data_rdata_o, 32'h0);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

`ifdef DMEM_WAIT_STATE_EN
    // Request withdrawn during WAIT: no grant, counter cleared.
    we   = 1'b0;
    addr = 32'h0001_0000;
    req  = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("wait_drop_gnt", {31'b0, data_gnt_o}, 32'h0);
    @(posedge clk);
    #1;
    check("wait_drop_cnt", 32'(dut.cnt_q), 32'h0);
    idle(2);
`endif

    // Table-driven transactions, issued back-to-back.
    for (int i = 0; i < 18; i++) run_vec(vecs[i]);
    idle(3);

    // Reset right after an accept: the pending response is discarded.
    v = '{1'b0, 32'h0001_0004, 4'hF, 32'h0, 32'h77FE_F00D};
    run_vec(v);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_gnt", {31'b0, data_gnt_o}, 32'h0);
      check("midrst_rvalid", {31'b0, data_rvalid_o}, 32'h0);
      check("midrst_rdata", data_rdata_o, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // First cycle after release accepts normally.
    v = '{1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h1357_2468};
    run_vec(v);
    idle(3);

`ifdef DMEM_WAIT_STATE_EN
    // Reset while waiting for a grant.
    we   = 1'b0;
    addr = 32'h0001_0004;
    req  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("waitrst_gnt", {31'b0, data_gnt_o}, 32'h0);
      check("waitrst_rvalid", {31'b0, data_rvalid_o}, 32'h0);
      check("waitrst_cnt", 32'(dut.cnt_q), 32'h0);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
`endif

    // Eight sequential words written, then read back with req held high.
    for (int k = 0; k < 8; k++) begin
      v = '{1'b1, BASE_ADDR + 32'(4 * k), 4'hF, 32'hA5A5_0000 + 32'(k), 32'h0};
      run_vec(v);
    end
    idle(2);
    acc_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      v = '{1'b0, BASE_ADDR + 32'(4 * k), 4'hF, 32'h0, 32'hA5A5_0000 + 32'(k)};
      run_vec(v);
    end
    idle(3);
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd8);
    if (acc_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++)
        check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(EXP_DIFF));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_cv32e_data_mem_slave
